// File: rtl/hpdmc_burst_dp_pkg.sv
// Shared types and constants for the HPDMC burst data path.
package hpdmc_burst_dp_pkg;

   localparam int         BURST_WORDS_DEF  = 4;
   localparam int         RD_DELAY_MAX_DEF = 7;
   localparam int         TWTR_DEF         = 2;
   localparam logic [3:0] MASK_ALL         = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_LEAD,
      ST_WR_DATA,
      ST_WR_TAIL,
      ST_RD_GAP
   } dp_state_t;

endpackage

// File: rtl/hpdmc_burst_dp_rd_tracker.sv
// Read tracker: one bit per future cycle; bit 0 set means di carries read data now.
module hpdmc_rd_tracker #(
   parameter int BURST_WORDS  = 4,
   parameter int RD_DELAY_MAX = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [2:0] delay,
   output logic       capture,
   output logic       empty
);

   localparam int            TW  = RD_DELAY_MAX + BURST_WORDS;
   localparam logic [TW-1:0] RUN = TW'((1 << BURST_WORDS) - 1);

   logic [TW-1:0] trk;
   logic [TW-1:0] run_at;

   always_comb run_at = load ? (RUN << delay) : '0;

   // The run is placed at offset delay and shifted in the same edge, so bit 0
   // lands exactly delay cycles after the accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) trk <= '0;
      else        trk <= (trk | run_at) >> 1;
   end

   assign capture = trk[0];
   assign empty   = (trk == '0);

   a_read_window : assert property (@(posedge clk) disable iff (!rst_n)
      load |-> (delay != 3'd0 && int'(delay) <= RD_DELAY_MAX &&
                (trk & (RUN << delay)) == '0));

endmodule

// File: rtl/hpdmc_burst_dp.sv
// Burst data path between the HPDMC scheduler and hpdmc_ddrio: write sourcing,
// read capture, bus turnaround and read/write spacing.
module hpdmc_burst_dp
   import hpdmc_burst_dp_pkg::*;
#(
   parameter int BURST_WORDS  = BURST_WORDS_DEF,
   parameter int RD_DELAY_MAX = RD_DELAY_MAX_DEF,
   parameter int TWTR         = TWTR_DEF
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cmd_valid,
   input  logic        cmd_write,
   output logic        cmd_ready,
   input  logic [2:0]  read_delay,
   input  logic [1:0]  write_delay,
   output logic        wr_ready,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_mask,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        direction,
   output logic [31:0] ddr_do,
   output logic [3:0]  mo,
   input  logic [31:0] di,
   output logic        busy
);

   localparam int CW = $clog2(BURST_WORDS + TWTR + 4) + 1;

   dp_state_t     state;
   logic [CW-1:0] cnt;
   logic          trk_capture, trk_empty, trk_was_busy;
   logic          turnaround, accept, acc_wr, acc_rd;

   assign turnaround = !trk_empty || trk_was_busy;
   assign accept     = cmd_valid && cmd_ready;
   assign acc_wr     = accept && cmd_write;
   assign acc_rd     = accept && !cmd_write;
   assign busy       = (state != ST_IDLE) || !trk_empty;

   always_comb begin
      cmd_ready = 1'b0;
      case (state)
         ST_IDLE:    cmd_ready = cmd_write ? !turnaround : 1'b1;
         ST_WR_TAIL: cmd_ready = cmd_write && !turnaround;
         default:    cmd_ready = 1'b0;
      endcase
   end

   hpdmc_rd_tracker #(
      .BURST_WORDS  (BURST_WORDS),
      .RD_DELAY_MAX (RD_DELAY_MAX)
   ) u_trk (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .load    (acc_rd),
      .delay   (read_delay),
      .capture (trk_capture),
      .empty   (trk_empty)
   );

   // wr_ready is registered, so a write_delay of 0 behaves as 1.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         wr_ready  <= 1'b0;
         direction <= 1'b1;
         ddr_do    <= '0;
         mo        <= MASK_ALL;
      end else begin
         case (state)
            ST_IDLE, ST_WR_TAIL: begin
               if (acc_wr) begin
                  cnt <= '0;
                  if (write_delay <= 2'd1) begin
                     state     <= ST_WR_DATA;
                     wr_ready  <= 1'b1;
                     direction <= 1'b0;
                  end else begin
                     state <= ST_WR_LEAD;
                     cnt   <= CW'(write_delay - 2'd2);
                  end
               end else if (acc_rd) begin
                  cnt   <= '0;
                  state <= (BURST_WORDS > 1) ? ST_RD_GAP : ST_IDLE;
               end else if (state == ST_WR_TAIL) begin
                  if (cnt == CW'(TWTR - 1)) state <= ST_IDLE;
                  else                      cnt   <= cnt + CW'(1);
               end
            end
            ST_WR_LEAD: begin
               if (cnt == '0) begin
                  state     <= ST_WR_DATA;
                  wr_ready  <= 1'b1;
                  direction <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_WR_DATA: begin
               if (wr_ready) begin
                  ddr_do <= wr_data;
                  mo     <= wr_mask;
                  cnt    <= cnt + CW'(1);
                  if (cnt == CW'(BURST_WORDS - 1)) wr_ready <= 1'b0;
               end else begin
                  // Last word is on the pins this cycle; release the bus after it.
                  mo        <= MASK_ALL;
                  direction <= 1'b1;
                  cnt       <= '0;
                  state     <= (TWTR > 0) ? ST_WR_TAIL : ST_IDLE;
               end
            end
            ST_RD_GAP: begin
               if (cnt == CW'(BURST_WORDS - 2)) state <= ST_IDLE;
               else                             cnt   <= cnt + CW'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_valid     <= 1'b0;
         rd_data      <= '0;
         trk_was_busy <= 1'b0;
      end else begin
         rd_valid     <= trk_capture;
         trk_was_busy <= !trk_empty;
         if (trk_capture) rd_data <= di;
      end
   end

endmodule

// File: tb/tb_hpdmc_burst_dp.sv
// Directed bench for hpdmc_burst_dp with a cycle-schedule reference model.
module tb_hpdmc_burst_dp;

   localparam int BW   = 4;
   localparam int TWTR = 2;
   localparam int MAXC = 512;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        cmd_valid, cmd_write, cmd_ready;
   logic [2:0]  read_delay;
   logic [1:0]  write_delay;
   logic        wr_ready;
   logic [31:0] wr_data;
   logic [3:0]  wr_mask;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        direction;
   logic [31:0] ddr_do;
   logic [3:0]  mo;
   logic [31:0] di;
   logic        busy;

   hpdmc_burst_dp #(.BURST_WORDS(BW), .RD_DELAY_MAX(7), .TWTR(TWTR)) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_write   (cmd_write),
      .cmd_ready   (cmd_ready),
      .read_delay  (read_delay),
      .write_delay (write_delay),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .wr_mask     (wr_mask),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .direction   (direction),
      .ddr_do      (ddr_do),
      .mo          (mo),
      .di          (di),
      .busy        (busy)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int total = 0, bad = 0;
   int scen = 0, base = 0;

   // stimulus history, indexed by the cycle it was driven
   logic [31:0] wd_hist [MAXC];
   logic [3:0]  wm_hist [MAXC];
   logic [31:0] di_hist [MAXC];

   // expected schedule, indexed by cycle
   bit e_wrr  [MAXC];
   bit e_drv  [MAXC];
   bit e_busy [MAXC];
   int e_do_src [MAXC];
   int e_rd_src [MAXC];
   int wr_ok, rd_ok;
   logic [31:0] last_do, last_rd;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d rel=%0d got=%h want=%h", name, cyc, cyc - base, got, exp);
      end
   endtask

   task automatic pin(input int sc, input int r, input string name,
                      input logic [31:0] got, input logic [31:0] exp);
      if (scen == sc && cyc - base == r) chk(name, got, exp);
   endtask

   always @(negedge sys_clk) begin
      int c, w, r;
      bit exp_rdy;
      c = cyc;
      if (!sys_rst_n) begin
         chk("rst_direction", {31'b0, direction}, 32'd1);
         chk("rst_mo", {28'b0, mo}, 32'hF);
         chk("rst_do", ddr_do, 32'd0);
         chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
         chk("rst_rd_data", rd_data, 32'd0);
         chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
         chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
         chk("rst_busy", {31'b0, busy}, 32'd0);
         for (int k = c; k < MAXC; k++) begin
            e_wrr[k] = 0; e_drv[k] = 0; e_busy[k] = 0;
            e_do_src[k] = -1; e_rd_src[k] = -1;
         end
         wr_ok = 0; rd_ok = 0; last_do = '0; last_rd = '0;
      end else begin
         exp_rdy = cmd_write ? (c >= wr_ok) : (c >= rd_ok);
         if (e_do_src[c] >= 0) last_do = wd_hist[e_do_src[c]];
         if (e_rd_src[c] >= 0) last_rd = di_hist[e_rd_src[c]];
         chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_rdy});
         chk("wr_ready", {31'b0, wr_ready}, {31'b0, e_wrr[c]});
         chk("direction", {31'b0, direction}, {31'b0, !e_drv[c]});
         chk("do", ddr_do, last_do);
         chk("mo", {28'b0, mo}, {28'b0, (e_do_src[c] >= 0) ? wm_hist[e_do_src[c]] : 4'hF});
         chk("rd_valid", {31'b0, rd_valid}, {31'b0, e_rd_src[c] >= 0});
         chk("rd_data", rd_data, last_rd);
         chk("busy", {31'b0, busy}, {31'b0, e_busy[c]});
         if (cmd_valid && exp_rdy) begin
            if (cmd_write) begin
               w = int'(write_delay);
               for (int i = 0; i < BW; i++) begin
                  e_wrr[c+w+i] = 1;
                  e_do_src[c+w+1+i] = c + w + i;
               end
               for (int k = c + w; k <= c + w + BW; k++) e_drv[k] = 1;
               for (int k = c + 1; k <= c + w + BW + TWTR; k++) e_busy[k] = 1;
               wr_ok = c + w + BW + 1;
               rd_ok = c + w + BW + 1 + TWTR;
            end else begin
               r = int'(read_delay);
               for (int i = 0; i < BW; i++) e_rd_src[c+r+1+i] = c + r + i;
               for (int k = c + 1; k <= c + r + BW - 1; k++) e_busy[k] = 1;
               if (c + BW > rd_ok) rd_ok = c + BW;
               if (c + r + BW + 1 > wr_ok) wr_ok = c + r + BW + 1;
            end
         end
      end
      // hand-computed anchors
      pin(1, 10, "s1_wrr10", {31'b0, wr_ready}, 32'd0);
      pin(1, 11, "s1_wrr11", {31'b0, wr_ready}, 32'd1);
      pin(1, 14, "s1_wrr14", {31'b0, wr_ready}, 32'd1);
      pin(1, 15, "s1_wrr15", {31'b0, wr_ready}, 32'd0);
      pin(1, 12, "s1_do12", ddr_do, 32'hA5A5_0001);
      pin(1, 15, "s1_do15", ddr_do, 32'hA5A5_0004);
      pin(1, 10, "s1_dir10", {31'b0, direction}, 32'd1);
      pin(1, 11, "s1_dir11", {31'b0, direction}, 32'd0);
      pin(1, 15, "s1_dir15", {31'b0, direction}, 32'd0);
      pin(1, 16, "s1_dir16", {31'b0, direction}, 32'd1);
      pin(1, 11, "s1_mo11", {28'b0, mo}, 32'hF);
      pin(1, 12, "s1_mo12", {28'b0, mo}, 32'h3);
      pin(1, 15, "s1_mo15", {28'b0, mo}, 32'h6);
      pin(1, 16, "s1_mo16", {28'b0, mo}, 32'hF);
      pin(2, 23, "s2_rdv23", {31'b0, rd_valid}, 32'd0);
      pin(2, 24, "s2_rdv24", {31'b0, rd_valid}, 32'd1);
      pin(2, 27, "s2_rdv27", {31'b0, rd_valid}, 32'd1);
      pin(2, 28, "s2_rdv28", {31'b0, rd_valid}, 32'd0);
      pin(2, 24, "s2_rdd24", rd_data, 32'h117);
      pin(2, 27, "s2_rdd27", rd_data, 32'h11A);
      pin(3, 21, "s3_rdy21", {31'b0, cmd_ready}, 32'd0);
      pin(3, 23, "s3_rdy23", {31'b0, cmd_ready}, 32'd0);
      pin(3, 24, "s3_rdy24", {31'b0, cmd_ready}, 32'd1);
      pin(3, 31, "s3_rdv31", {31'b0, rd_valid}, 32'd1);
      pin(3, 32, "s3_rdv32", {31'b0, rd_valid}, 32'd0);
      pin(3, 31, "s3_rdd31", rd_data, 32'h11E);
      pin(4, 27, "s4_rdy27", {31'b0, cmd_ready}, 32'd0);
      pin(4, 28, "s4_rdy28", {31'b0, cmd_ready}, 32'd1);
      pin(4, 28, "s4_dir28", {31'b0, direction}, 32'd1);
      pin(4, 29, "s4_dir29", {31'b0, direction}, 32'd0);
      pin(5, 16, "s5_dir16", {31'b0, direction}, 32'd0);
      pin(5, 17, "s5_dir17", {31'b0, direction}, 32'd1);
      pin(5, 17, "s5_rdy17", {31'b0, cmd_ready}, 32'd0);
      pin(5, 18, "s5_rdy18", {31'b0, cmd_ready}, 32'd0);
      pin(5, 19, "s5_rdy19", {31'b0, cmd_ready}, 32'd1);
      pin(5, 45, "s5_rdy45", {31'b0, cmd_ready}, 32'd0);
      pin(5, 46, "s5_rdy46", {31'b0, cmd_ready}, 32'd1);
      pin(5, 48, "s5_wrr48", {31'b0, wr_ready}, 32'd0);
      pin(5, 49, "s5_wrr49", {31'b0, wr_ready}, 32'd1);
      pin(6, 24, "s6_rdv24", {31'b0, rd_valid}, 32'd1);
      pin(6, 25, "s6_rdv25", {31'b0, rd_valid}, 32'd0);
      pin(6, 25, "s6_busy25", {31'b0, busy}, 32'd0);
      pin(6, 29, "s6_rdy29", {31'b0, cmd_ready}, 32'd1);
      pin(6, 30, "s6_rdv30", {31'b0, rd_valid}, 32'd0);
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
      wr_data = {16'hA5A5, 16'(cyc - base - 10)};
      wr_mask = {1'b0, 3'(cyc - base)};
      di      = 32'h100 + 32'(cyc - base);
      wd_hist[cyc] = wr_data;
      wm_hist[cyc] = wr_mask;
      di_hist[cyc] = di;
   endtask

   task automatic at(input int r);
      while (cyc - base < r) tick();
   endtask

   task automatic start(input int s);
      scen = s;
      base = cyc + 1;
   endtask

   initial begin
      sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      read_delay = 3'd3; write_delay = 2'd1;
      wr_data = '0; wr_mask = '0; di = '0;
      repeat (3) tick();
      sys_rst_n = 1'b1;

      // single write, write_delay changed mid-burst
      start(1);
      at(10); cmd_valid = 1; cmd_write = 1; write_delay = 2'd1;
      at(11); cmd_valid = 0;
      at(12); write_delay = 2'd3;
      at(30);

      // single read, read_delay changed mid-burst
      start(2);
      at(20); cmd_valid = 1; cmd_write = 0; read_delay = 3'd3;
      at(21); cmd_valid = 0; read_delay = 3'd1;
      at(35);

      // back-to-back reads
      start(3);
      at(20); cmd_valid = 1; cmd_write = 0; read_delay = 3'd3;
      at(25); cmd_valid = 0;
      at(40);

      // read followed by a write: turnaround
      start(4);
      at(20); cmd_valid = 1; cmd_write = 0; read_delay = 3'd3;
      at(21); cmd_write = 1; write_delay = 2'd1;
      at(29); cmd_valid = 0;
      at(45);

      // write then read (TWTR), then write then write
      start(5);
      at(10); cmd_valid = 1; cmd_write = 1; write_delay = 2'd2;
      at(11); cmd_valid = 0;
      at(13); cmd_valid = 1; cmd_write = 0; read_delay = 3'd2;
      at(20); cmd_valid = 0;
      at(40); cmd_valid = 1; cmd_write = 1; write_delay = 2'd1;
      at(41); write_delay = 2'd3;
      at(47); cmd_valid = 0;
      at(70);

      // reset in the middle of a read burst
      start(6);
      at(20); cmd_valid = 1; cmd_write = 0; read_delay = 3'd3;
      at(21); cmd_valid = 0;
      at(25); sys_rst_n = 1'b0;
      at(28); sys_rst_n = 1'b1; cmd_write = 1;
      at(35);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
